// File: rtl/filter_pad_gen_if.sv
// Pixel stream bundle between an upstream source and filter_pad_gen.
// slave  : the padding block (consumes iValid/iData, produces the rest).
// master : the upstream source / downstream sink side.
interface filter_pad_gen_if;
  logic        iValid;
  logic [23:0] iData;
  logic        oReq;
  logic        oValid;
  logic [23:0] oData;
  logic        oDone;
  logic        oOverflow;

  modport slave (
    input  iValid, iData,
    output oReq, oValid, oData, oDone, oOverflow
  );

  modport master (
    output iValid, iData,
    input  oReq, oValid, oData, oDone, oOverflow
  );
endinterface

// File: rtl/filter_pad_gen.sv
// Frame padder: wraps each width x height image in a B-pixel zero border
// (B = (kernel_size-1)/2) so a kernel_size filter downstream sees full frames.
// Output registered, 1 cycle after the decision; first pixel 3 cycles after first write.
// Ports: clk, reset (sync, active-high), px (slave: iValid/iData in,
//        oReq/oValid/oData/oDone/oOverflow out). Only ACTIVE stalls on an empty FIFO.
module filter_pad_gen #(
  parameter int width       = 320,
  parameter int height      = 240,
  parameter int kernel_size = 3,
  parameter int fifo_depth  = 16
) (
  input  logic          clk,
  input  logic          reset,
  filter_pad_gen_if.slave px
);

  localparam int B       = (kernel_size - 1) / 2;
  localparam int ROW_LEN = width + 2 * B;
  localparam int PAD_LEN = B * ROW_LEN;
  localparam int AW      = $clog2(fifo_depth);
  localparam int CW      = 16;

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, TOP, LEFT, ACTIVE, RIGHT, BOTTOM} state_t;

  localparam cnt_t          PAD_LAST  = cnt_t'(PAD_LEN - 1);
  localparam cnt_t          B_LAST    = cnt_t'(B - 1);
  localparam cnt_t          W_LAST    = cnt_t'(width - 1);
  localparam cnt_t          H_LAST    = cnt_t'(height - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(fifo_depth);
  localparam logic [AW:0]   REQ_MAX_C = (AW + 1)'(fifo_depth - 2);

  // ---------------- input FIFO (show-ahead) ----------------
  logic [23:0]   mem_q [fifo_depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, fifo_full, fifo_nonempty;
  logic          ovf_q;

  assign fifo_full     = (count_q == DEPTH_C);
  assign fifo_nonempty = (count_q != '0);
  // A full FIFO still takes a pixel when the head leaves in the same cycle,
  // so a simultaneous read/write never loses data.
  assign push          = px.iValid && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= px.iData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (px.iValid && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign px.oReq      = (count_q <= REQ_MAX_C);
  assign px.oOverflow = ovf_q;

  // ---------------- frame sequencer ----------------
  state_t      state_q, state_d;
  cnt_t        col_q, col_d;     // pixel index inside the current state run
  cnt_t        row_q, row_d;     // image row index
  logic        emit, done;
  logic [23:0] emit_dat;
  logic        vld_q, done_q;
  logic [23:0] dat_q;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    emit     = 1'b0;
    emit_dat = '0;
    pop      = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          state_d = TOP;
          col_d   = '0;
          row_d   = '0;
        end
      end
      TOP: begin
        emit = 1'b1;
        if (col_q == PAD_LAST) begin
          state_d = LEFT;
          col_d   = '0;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      LEFT: begin
        emit = 1'b1;
        if (col_q == B_LAST) begin
          state_d = ACTIVE;
          col_d   = '0;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ACTIVE: begin
        // Empty FIFO: hold everything and emit nothing this cycle.
        if (fifo_nonempty) begin
          emit     = 1'b1;
          emit_dat = mem_q[rd_ptr_q];
          pop      = 1'b1;
          if (col_q == W_LAST) begin
            state_d = RIGHT;
            col_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      RIGHT: begin
        emit = 1'b1;
        if (col_q == B_LAST) begin
          col_d = '0;
          if (row_q == H_LAST) begin
            state_d = BOTTOM;
            row_d   = '0;
          end else begin
            state_d = LEFT;
            row_d   = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      BOTTOM: begin
        emit = 1'b1;
        if (col_q == PAD_LAST) begin
          state_d = IDLE;
          col_d   = '0;
          done    = 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      vld_q   <= emit;
      dat_q   <= emit_dat;
      done_q  <= done;
    end
  end

  assign px.oValid = vld_q;
  assign px.oData  = dat_q;
  assign px.oDone  = done_q;

endmodule

// File: tb/tb_filter_pad_gen.sv
`timescale 1ns/1ps
module tb_filter_pad_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int KS   = 3;
  localparam int B    = (KS - 1) / 2;
  localparam int RL   = W + 2 * B;
  localparam int NFR  = RL * (H + 2 * B);
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [23:0] in_dat;
  logic        sel;          // 0: depth-16 instance, 1: depth-4 instance
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  filter_pad_gen_if if16();
  filter_pad_gen_if if4();

  assign if16.iValid = in_vld & ~sel;
  assign if16.iData  = in_dat;
  assign if4.iValid  = in_vld & sel;
  assign if4.iData   = in_dat;

  filter_pad_gen #(.width(W), .height(H), .kernel_size(KS), .fifo_depth(16))
    dut16 (.clk(clk), .reset(rst), .px(if16));
  filter_pad_gen #(.width(W), .height(H), .kernel_size(KS), .fifo_depth(4))
    dut4  (.clk(clk), .reset(rst), .px(if4));

  logic        mon_vld, mon_req, mon_done, mon_ovf;
  logic [23:0] mon_dat;
  assign mon_vld  = sel ? if4.oValid    : if16.oValid;
  assign mon_req  = sel ? if4.oReq      : if16.oReq;
  assign mon_done = sel ? if4.oDone     : if16.oDone;
  assign mon_ovf  = sel ? if4.oOverflow : if16.oOverflow;
  assign mon_dat  = sel ? if4.oData     : if16.oData;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [23:0] img[$];
  logic [23:0] tmp[$];
  logic [23:0] got_dat[$];
  int          got_cyc[$];
  logic        got_done[$];
  int          zero_bad;
  logic        timed_out;
  int          first_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: pixel idx of a padded frame built from the image in arrival order.
  function automatic logic [23:0] pad_px(input logic [23:0] im[$], input int idx);
    int r;
    int c;
    r = idx / RL;
    c = idx % RL;
    if (r < B || r >= H + B || c < B || c >= W + B) return 24'h0;
    return im[(r - B) * W + (c - B)];
  endfunction

  function automatic bit is_pad(input int idx);
    int r;
    int c;
    r = idx / RL;
    c = idx % RL;
    return (r < B || r >= H + B || c < B || c >= W + B);
  endfunction

  // Called at posedge+1; drives one pixel per accepted cycle with 'gap' idle cycles before each.
  task automatic send(input logic [23:0] px[$], input int gap, input bit gate);
    for (int i = 0; i < px.size(); i++) begin
      for (int g = 0; g < gap; g++) begin
        in_vld = 1'b0;
        @(posedge clk); #1;
      end
      if (gate) begin
        int w = 0;
        while (!mon_req && w < 1000) begin
          in_vld = 1'b0;
          @(posedge clk); #1;
          w++;
        end
      end
      in_vld = 1'b1;
      in_dat = px[i];
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    int waited = 0;
    got_dat.delete();
    got_cyc.delete();
    got_done.delete();
    zero_bad  = 0;
    timed_out = 1'b0;
    while (got_dat.size() < n) begin
      @(negedge clk);
      if (mon_vld) begin
        got_dat.push_back(mon_dat);
        got_cyc.push_back(cyc);
        got_done.push_back(mon_done);
      end else if (mon_dat !== 24'h0 || mon_done !== 1'b0) begin
        zero_bad++;
      end
      waited++;
      if (waited > budget) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [23:0] im[$], input int base);
    int mism = 0;
    int first = -1;
    int dones = 0;
    int done_at = -1;
    for (int i = 0; i < NFR; i++) begin
      if (got_dat[base + i] !== pad_px(im, i)) begin
        mism++;
        if (first < 0) first = i;
      end
      if (got_done[base + i] === 1'b1) begin
        dones++;
        done_at = i;
      end
    end
    chk({tag, " pixel mismatches"}, mism, 0);
    chk({tag, " oDone count"}, dones, 1);
    chk({tag, " oDone index"}, done_at, NFR - 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst    = 1'b1;
    in_vld = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b0;
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(24'($urandom_range(24'hFFFFFF, 1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    in_vld = 1'b0;
    in_dat = 24'h0;
    sel    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state of both instances
    chk("rst oValid16", if16.oValid, 0);
    chk("rst oData16", if16.oData, 0);
    chk("rst oDone16", if16.oDone, 0);
    chk("rst oOvf16", if16.oOverflow, 0);
    chk("rst oReq16", if16.oReq, 1);
    chk("rst oValid4", if4.oValid, 0);
    chk("rst oReq4", if4.oReq, 1);
    // iValid during reset is ignored
    in_vld = 1'b1;
    in_dat = 24'hABCDEF;
    @(posedge clk); #1;
    in_vld = 1'b0;
    rst    = 1'b0;

    // Smoke: 1..12 back-to-back into depth 16
    img.delete();
    for (int i = 1; i <= NPIX; i++) img.push_back(24'(i));
    first_cyc = cyc;
    fork
      send(img, 0, 1);
      collect(NFR, 300);
    join
    chk("smoke timeout", timed_out, 0);
    chk("smoke count", got_dat.size(), NFR);
    check_frame("smoke", img, 0);
    chk("smoke latency", got_cyc[0] - first_cyc, 3);
    chk("smoke idle data zero", zero_bad, 0);

    // Starvation: one pixel every 5 cycles
    do_reset();
    rand_img(NPIX);
    fork
      send(img, 4, 1);
      collect(NFR, 600);
    join
    chk("starve timeout", timed_out, 0);
    check_frame("starve", img, 0);
    begin
      int stalls = 0;
      int bad = 0;
      for (int i = 1; i < NFR; i++) begin
        if (got_cyc[i] - got_cyc[i - 1] > 1) begin
          stalls++;
          if (is_pad(i)) bad++;
        end
      end
      chk("starve stalls seen", stalls > 0, 1);
      chk("starve gap before padding", bad, 0);
    end
    chk("starve idle data zero", zero_bad, 0);

    // Backpressure: depth 4, iValid only while oReq
    sel = 1'b1;
    do_reset();
    rand_img(NPIX);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          chk("bp oReq before write", mon_req, 1);
          in_vld = 1'b1;
          in_dat = img[i];
          @(posedge clk); #1;
        end
        in_vld = 1'b0;
        chk("bp oReq at count 3", mon_req, 0);
        tmp = img[3:$];
        send(tmp, 0, 1);
      end
      collect(NFR, 600);
    join
    chk("bp timeout", timed_out, 0);
    check_frame("bp", img, 0);
    chk("bp no overflow", mon_ovf, 0);

    // Overflow: depth 4, iValid held high through the TOP border
    do_reset();
    rand_img(NPIX);
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          if (i == 4) chk("ovf clear at count 4", mon_ovf, 0);
          if (i == 5) chk("ovf set on write at full", mon_ovf, 1);
          in_vld = 1'b1;
          in_dat = (i < 4) ? img[i] : 24'($urandom_range(24'hFFFFFF, 1));
          @(posedge clk); #1;
        end
        in_vld = 1'b0;
        tmp = img[4:$];
        send(tmp, 0, 1);
      end
      collect(NFR, 600);
    join
    chk("ovf timeout", timed_out, 0);
    check_frame("ovf", img, 0);
    chk("ovf sticky", mon_ovf, 1);
    do_reset();
    chk("ovf cleared by reset", mon_ovf, 0);

    // Back-to-back frames: 24 pixels, depth 16
    sel = 1'b0;
    do_reset();
    rand_img(2 * NPIX);
    fork
      send(img, 0, 1);
      collect(2 * NFR, 600);
    join
    chk("b2b timeout", timed_out, 0);
    tmp = img[0:NPIX-1];
    check_frame("b2b f0", tmp, 0);
    tmp = img[NPIX:$];
    check_frame("b2b f1", tmp, NFR);
    chk("b2b single idle gap", got_cyc[NFR] - got_cyc[NFR - 1], 2);

    // Mid-frame reset after 10 output pixels
    do_reset();
    rand_img(NPIX);
    fork
      send(img, 0, 1);
      collect(10, 300);
    join
    chk("mid timeout", timed_out, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid oValid after reset", mon_vld, 0);
    chk("mid oReq after reset", mon_req, 1);
    chk("mid oOvf after reset", mon_ovf, 0);
    collect(1, 20);
    chk("mid silent after reset", got_dat.size(), 0);
    @(posedge clk); #1;
    rand_img(NPIX);
    fork
      send(img, 0, 1);
      collect(NFR, 300);
    join
    chk("mid2 timeout", timed_out, 0);
    check_frame("mid2", img, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
